// File: rtl/uart_rgb_rx.sv
// UART 8N1 receiver and 5-byte colour packet parser.
// Publishes RGB duty values for the PWM stage on each good packet.
module uart_rgb_rx #(
  parameter int CLOCKS_PER_BIT = 86,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_rxd,
  output logic [7:0] duty_red,
  output logic [7:0] duty_green,
  output logic [7:0] duty_blue,
  output logic       duty_valid,
  output logic       frame_err,
  output logic       pkt_err
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS * CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   =
    TW'(TIMEOUT_BITS * CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } bit_state_t;

  typedef enum logic [2:0] {
    HDR, PKT_R, PKT_G, PKT_B, PKT_CHK
  } pkt_state_t;

  logic rx_meta, rx_s;

  bit_state_t bs_q, bs_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic byte_valid, stop_bad;

  pkt_state_t ps_q, ps_d;
  logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic [7:0] red_d, green_d, blue_d;
  logic [TW-1:0] to_q, to_d;
  logic dv_d, pe_d;

  // Two-flop synchroniser; idle-high reset avoids a false start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_rxd;
      rx_s    <= rx_meta;
    end
  end

  // Bit engine next-state: mid-bit sampling after a half-bit start check
  always_comb begin
    bs_d       = bs_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    case (bs_q)
      IDLE: begin
        baud_d    = '0;
        bit_cnt_d = '0;
        if (!rx_s) bs_d = START;
      end
      START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          bs_d   = rx_s ? IDLE : DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d    = '0;
          sh_d      = {rx_s, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) bs_d = STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d     = '0;
          bs_d       = IDLE;
          byte_valid = rx_s;
          stop_bad   = !rx_s;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: bs_d = IDLE;
    endcase
  end

  // Bit engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs_q      <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      frame_err <= 1'b0;
    end else begin
      bs_q      <= bs_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      frame_err <= stop_bad;
    end
  end

  // Packet parser next-state; framing error beats timeout, byte beats both
  always_comb begin
    ps_d    = ps_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    red_d   = duty_red;
    green_d = duty_green;
    blue_d  = duty_blue;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    to_d    = (ps_q == HDR || byte_valid) ? '0 : to_q + TW'(1);
    if (stop_bad) begin
      ps_d = HDR;
    end else if (byte_valid) begin
      case (ps_q)
        HDR: if (sh_q == 8'hA5) ps_d = PKT_R;
        PKT_R: begin
          r_d  = sh_q;
          ps_d = PKT_G;
        end
        PKT_G: begin
          g_d  = sh_q;
          ps_d = PKT_B;
        end
        PKT_B: begin
          b_d  = sh_q;
          ps_d = PKT_CHK;
        end
        PKT_CHK: begin
          ps_d = HDR;
          if (sh_q == (r_q ^ g_q ^ b_q)) begin
            red_d   = r_q;
            green_d = g_q;
            blue_d  = b_q;
            dv_d    = 1'b1;
          end else begin
            pe_d = 1'b1;
          end
        end
        default: ps_d = HDR;
      endcase
    end else if (ps_q != HDR && to_q == TO_LAST) begin
      ps_d = HDR;
      pe_d = 1'b1;
    end
  end

  // Parser state, shadows, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q       <= HDR;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      to_q       <= '0;
      duty_red   <= '0;
      duty_green <= '0;
      duty_blue  <= '0;
      duty_valid <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      to_q       <= to_d;
      duty_red   <= red_d;
      duty_green <= green_d;
      duty_blue  <= blue_d;
      duty_valid <= dv_d;
      pkt_err    <= pe_d;
    end
  end

endmodule

// File: tb/tb_uart_rgb_rx.sv
// Bench for uart_rgb_rx: directed scenarios plus random packets.
// Expected results come from a byte-buffer packet model.
module tb_uart_rgb_rx;

  localparam int CPB = 8;
  localparam int TOB = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_rxd = 1'b1;
  logic [7:0] duty_red, duty_green, duty_blue;
  logic       duty_valid, frame_err, pkt_err;

  uart_rgb_rx #(
    .CLOCKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .serial_rxd(serial_rxd),
    .duty_red(duty_red),
    .duty_green(duty_green),
    .duty_blue(duty_blue),
    .duty_valid(duty_valid),
    .frame_err(frame_err),
    .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor
  int dv_seen = 0, pe_seen = 0, fe_seen = 0;
  int dv_cyc = 0, pe_cyc = 0, viol = 0;
  logic dv_p = 1'b0, pe_p = 1'b0, fe_p = 1'b0;

  always @(negedge clk) begin
    if (duty_valid) begin
      dv_seen <= dv_seen + 1;
      dv_cyc  <= cyc;
    end
    if (pkt_err) begin
      pe_seen <= pe_seen + 1;
      pe_cyc  <= cyc;
    end
    if (frame_err) fe_seen <= fe_seen + 1;
    if ((duty_valid && dv_p) || (pkt_err && pe_p) ||
        (frame_err && fe_p) || (duty_valid && pkt_err))
      viol <= viol + 1;
    dv_p <= duty_valid;
    pe_p <= pkt_err;
    fe_p <= frame_err;
  end

  // Reference model
  logic [7:0] pkt[$];
  logic [7:0] exp_r = 8'h00, exp_g = 8'h00, exp_b = 8'h00;
  int exp_dv = 0, exp_pe = 0, exp_fe = 0;
  int checks = 0, errors = 0;
  int last_start = 0;

  function automatic void model_byte(input logic [7:0] b);
    if (pkt.size() == 0) begin
      if (b == 8'hA5) pkt.push_back(b);
    end else begin
      pkt.push_back(b);
      if (pkt.size() == 5) begin
        if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
          exp_r = pkt[1];
          exp_g = pkt[2];
          exp_b = pkt[3];
          exp_dv++;
        end else begin
          exp_pe++;
        end
        pkt.delete();
      end
    end
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    serial_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      serial_rxd = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    serial_rxd = 1'b1;
    if (stop_ok) model_byte(b);
    else begin
      exp_fe++;
      pkt.delete();
    end
  endtask

  task automatic send_pkt(input logic [7:0] h, r, g, b, c);
    send_byte(h, 1'b1);
    send_byte(r, 1'b1);
    send_byte(g, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic check_state(input string tag);
    idle(4);
    chk({tag, "_dv"}, dv_seen, exp_dv);
    chk({tag, "_pe"}, pe_seen, exp_pe);
    chk({tag, "_fe"}, fe_seen, exp_fe);
    chk({tag, "_red"}, duty_red, exp_r);
    chk({tag, "_green"}, duty_green, exp_g);
    chk({tag, "_blue"}, duty_blue, exp_b);
  endtask

  initial begin
    int t0, d;
    logic [7:0] r, g, b, c;

    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;
    idle(5);

    send_pkt(8'hA5, 8'h10, 8'h20, 8'h30, 8'h00);
    d = dv_cyc - last_start;
    chk("dv_latency", int'(d >= 78 && d <= 80), 1);
    check_state("valid");

    send_pkt(8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00);
    check_state("badchk");

    send_byte(8'hA5, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(2 * CPB);
    check_state("frame");
    send_pkt(8'hA5, 8'h01, 8'h02, 8'h04, 8'h07);
    check_state("resync");

    serial_rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(4 * CPB);
    check_state("glitch");

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_pkt(8'hA5, 8'hAA, 8'h55, 8'h00, 8'hFF);
    check_state("noise");

    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    t0 = last_start;
    idle(200);
    exp_pe++;
    pkt.delete();
    d = pe_cyc - t0;
    chk("to_latency", int'(d >= 235 && d <= 241), 1);
    check_state("timeout");
    send_pkt(8'hA5, 8'h11, 8'h22, 8'h33, 8'h00);
    check_state("after_to");

    for (int k = 0; k < 6; k++) begin
      int nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++)
        send_byte(8'($urandom_range(0, 164)), 1'b1);
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      c = r ^ g ^ b;
      if ($urandom_range(0, 2) == 0)
        c = c ^ 8'($urandom_range(1, 255));
      send_pkt(8'hA5, r, g, b, c);
      check_state("rand");
    end

    send_pkt(8'hA5, 8'h5A, 8'h6B, 8'h7C, 8'h5A ^ 8'h6B ^ 8'h7C);
    check_state("pre_rst");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_r = 8'h00;
    exp_g = 8'h00;
    exp_b = 8'h00;
    pkt.delete();
    chk("rst_red", duty_red, 0);
    chk("rst_green", duty_green, 0);
    chk("rst_blue", duty_blue, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3);
    send_byte(8'h33, 1'b1);
    send_byte(8'h00, 1'b1);
    check_state("post_rst");

    chk("strobe_rules", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rgb_rx.md
# uart_rgb_rx

Serial command receiver that feeds the RGB PWM stage. It deserialises 8N1 UART bytes from `serial_rxd` and parses 5-byte colour packets. On each valid packet it publishes new 8-bit duty values for red, green and blue, plus a one-cycle update strobe. It sits between the FTDI receive pin and the PWM generator that drives the active-low LED pins.

## Interface
- `CLOCKS_PER_BIT`, 86: clock cycles per UART bit (10 MHz / 115200). Minimum 4.
- `TIMEOUT_BITS`, 20: idle bit periods allowed between bytes of one packet before the parser aborts.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `serial_rxd` in 1: UART receive line from USB; idles high; asynchronous to `clk`.
- `duty_red` out 8: red duty value. 0 = off, 255 = max.
- `duty_green` out 8: green duty value.
- `duty_blue` out 8: blue duty value.
- `duty_valid` out 1: one-cycle pulse in the cycle the duty outputs change.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `pkt_err` out 1: one-cycle pulse on a checksum mismatch or an inter-byte timeout.

## Operation
- Input path: 2-flop synchroniser on `serial_rxd`. Both flops reset to 1.
- Bit engine has four states:
  - IDLE: waits for a low level on the synchronised line.
  - START: counts `CLOCKS_PER_BIT/2` (integer division) and resamples. If the line is high, this was a glitch: return to IDLE. If low, go to DATA.
  - DATA: samples 8 bits, LSB first, every `CLOCKS_PER_BIT` cycles.
  - STOP: samples once after `CLOCKS_PER_BIT` cycles. High produces an internal `byte_valid` pulse. Low pulses `frame_err` and discards the byte. Either way, return to IDLE.
- Bit counter is 3 bits. Baud counter width is `$clog2(CLOCKS_PER_BIT)`.
- Packet format: `0xA5`, R, G, B, CHK, where CHK = R ^ G ^ B.
- Packet parser states:
  - HDR: bytes other than `0xA5` are ignored. `0xA5` moves to R.
  - R → G → B → CHK: each state latches the incoming byte into a shadow register.
  - CHK match: copy the shadows to the duty outputs, pulse `duty_valid`, return to HDR.
  - CHK mismatch: pulse `pkt_err`, leave the outputs unchanged, return to HDR.
- A `0xA5` arriving in R/G/B/CHK is treated as data, not as a resync.
- Framing error in any parser state: the parser returns to HDR. No `pkt_err` is raised; `frame_err` alone reports it.
- Timeout:
  - In R/G/B/CHK, a counter measures time since the last `byte_valid`.
  - Reaching `TIMEOUT_BITS*CLOCKS_PER_BIT` cycles pulses `pkt_err` and returns the parser to HDR.
  - The counter is cleared by `byte_valid` and while in HDR.
- Reset: all FSMs go to IDLE/HDR. Duty outputs, shadows and counters = 0. `duty_valid`, `frame_err`, `pkt_err` = 0.
- Reset asserted mid-byte or mid-packet discards everything in progress. The first packet after release must start with a fresh header.

## Timing
- All outputs are registered.
- `duty_valid` and the new duty values appear exactly 1 clk after the cycle in which the CHK byte's stop bit is sampled.
- That stop sample occurs 2 (synchroniser) + `CLOCKS_PER_BIT/2` + 9*`CLOCKS_PER_BIT` clocks after the start-bit falling edge on the pin, ±1 clk.
- `frame_err` is asserted 1 clk after the failing stop sample.
- `pkt_err` (checksum mismatch) is asserted 1 clk after the CHK stop sample.
- `pkt_err` (timeout) is asserted 1 clk after the terminal count.
- Back-to-back bytes with no idle time between them must be received. The bit engine is in IDLE before the next start edge can arrive.
- Error and valid strobes are never high for more than 1 cycle.
- `duty_valid` and `pkt_err` are never high in the same cycle.
- Duty outputs hold their values between updates.

## Test plan
- All scenarios use `CLOCKS_PER_BIT=8` and `TIMEOUT_BITS=20`.
- Valid packet: send `A5 10 20 30 00` (CHK 0x00) → one `duty_valid` pulse; outputs 0x10/0x20/0x30.
- Bad checksum: after the valid packet, send `A5 FF 00 00 00` → one `pkt_err` pulse; outputs remain 0x10/0x20/0x30; no `duty_valid`.
- Framing error then resync:
  - Send `A5 40`, then a byte whose stop bit is held low → `frame_err` pulse.
  - Then send `A5 01 02 04 07` → outputs 0x01/0x02/0x04 and one `duty_valid`.
- Glitch and noise:
  - A 3-cycle low pulse on the idle line → no byte, no strobes.
  - Send `00 FF A5 AA 55 00 FF` → junk bytes ignored; outputs 0xAA/0x55/0x00.
- Timeout: send `A5 11`, then idle 200 cycles → `pkt_err` exactly once at cycle 160 ±2 after the `11` byte's stop sample. Then `A5 11 22 33 00` is accepted.
- Reset mid-packet: send `A5 11 22`, pulse `rst_n` low asynchronously → outputs 0 immediately; then `33 00` produces no `duty_valid`.
